// File: rtl/pong_pkg.sv
// Shared Pong types and screen constants; sat_inc gives the non-wrapping score increment.
package pong_pkg;

  typedef enum logic [1:0] {IDLE, PLAY, POINT, GAME_OVER} score_state_t;

  localparam int SCREEN_W  = 640;
  localparam int SCREEN_H  = 480;
  localparam int BALL_HALF = 6;

  function automatic logic [3:0] sat_inc(input logic [3:0] s);
    return (s == 4'd15) ? s : s + 4'd1;
  endfunction

endpackage

// File: rtl/pong_serve_timer.sv
// Serve-delay counter: counts 0..SERVE_DELAY-1 while enabled, done flags the terminal count.
// Combinational done, no backpressure; load clears the count.
module pong_serve_timer #(
  parameter logic [31:0] SERVE_DELAY = 32'd50000000
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic done
);
  import pong_pkg::*;

  logic [31:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     count <= '0;
    else if (load) count <= '0;
    else if (en)   count <= count + 32'd1;
  end

  assign done = en && (count == SERVE_DELAY - 32'd1);

endmodule

// File: rtl/pong_score_keeper.sv
// Goal detection, scoring, serve hold and winner FSM; 1-cycle registered outputs, no backpressure.
// PONG_WIN_BY_TWO_EN: require a two-point lead to win (reaching 15 always wins).
module pong_score_keeper #(
  parameter logic [3:0]  WIN_SCORE    = 4'd7,
  parameter logic [9:0]  LEFT_GOAL_X  = 10'd4,
  parameter logic [9:0]  RIGHT_GOAL_X = 10'd636,
  parameter logic [9:0]  WRAP_GUARD   = 10'd1000,
  parameter logic [31:0] SERVE_DELAY  = 32'd50000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [9:0] ball_x_pos,
  output logic       ball_reset,
  output logic [3:0] left_score,
  output logic [3:0] right_score,
  output logic       point_pulse,
  output logic       game_over,
  output logic       winner
);
  import pong_pkg::*;

  score_state_t state;
  logic         start_q;
  logic         first_play;
  logic         start_rise;
  logic         left_goal, right_goal;
  logic [3:0]   l_next, r_next;
  logic         left_wins, right_wins;
  logic         serve_done;

  assign start_rise = start & ~start_q;
  // x at or above WRAP_GUARD is the ball wrapping past 0, so it belongs to the left goal
  assign left_goal  = (ball_x_pos <= LEFT_GOAL_X) || (ball_x_pos >= WRAP_GUARD);
  assign right_goal = (ball_x_pos >= RIGHT_GOAL_X) && (ball_x_pos < WRAP_GUARD);
  assign l_next     = sat_inc(left_score);
  assign r_next     = sat_inc(right_score);

`ifdef PONG_WIN_BY_TWO_EN
  assign left_wins  = (l_next == 4'd15) ||
                      ((l_next >= WIN_SCORE) && ({1'b0, l_next} >= {1'b0, right_score} + 5'd2));
  assign right_wins = (r_next == 4'd15) ||
                      ((r_next >= WIN_SCORE) && ({1'b0, r_next} >= {1'b0, left_score} + 5'd2));
`else
  assign left_wins  = (l_next >= WIN_SCORE);
  assign right_wins = (r_next >= WIN_SCORE);
`endif

  pong_serve_timer #(.SERVE_DELAY(SERVE_DELAY)) u_timer (
    .clk   (clk),
    .reset (reset),
    .load  ((state != POINT) || serve_done),
    .en    (state == POINT),
    .done  (serve_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      left_score  <= '0;
      right_score <= '0;
      ball_reset  <= 1'b1;
      point_pulse <= 1'b0;
      game_over   <= 1'b0;
      winner      <= 1'b0;
      start_q     <= 1'b0;
      first_play  <= 1'b0;
    end else begin
      start_q     <= start;
      point_pulse <= 1'b0;
      case (state)
        IDLE, GAME_OVER: begin
          if (start_rise) begin
            state       <= PLAY;
            left_score  <= '0;
            right_score <= '0;
            ball_reset  <= 1'b0;
            game_over   <= 1'b0;
            first_play  <= 1'b1;
          end
        end
        PLAY: begin
          // first PLAY cycle still sees the pre-serve x position
          if (first_play) begin
            first_play <= 1'b0;
          end else if (left_goal) begin
            right_score <= r_next;
            point_pulse <= 1'b1;
            ball_reset  <= 1'b1;
            if (right_wins) begin
              state     <= GAME_OVER;
              game_over <= 1'b1;
              winner    <= 1'b1;
            end else begin
              state <= POINT;
            end
          end else if (right_goal) begin
            left_score  <= l_next;
            point_pulse <= 1'b1;
            ball_reset  <= 1'b1;
            if (left_wins) begin
              state     <= GAME_OVER;
              game_over <= 1'b1;
              winner    <= 1'b0;
            end else begin
              state <= POINT;
            end
          end
        end
        POINT: begin
          if (serve_done) begin
            state      <= PLAY;
            ball_reset <= 1'b0;
            first_play <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pong_score_keeper.sv
// Randomized and directed bench for pong_score_keeper against a behavioural scoring model.
module tb_pong_score_keeper;

  localparam int W = 3;
  localparam int D = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [9:0] x_pos = 10'd320;
  logic       ball_reset;
  logic [3:0] left_score, right_score;
  logic       point_pulse, game_over, winner;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  pong_score_keeper #(.WIN_SCORE(4'd3), .SERVE_DELAY(32'd8)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .ball_x_pos  (x_pos),
    .ball_reset  (ball_reset),
    .left_score  (left_score),
    .right_score (right_score),
    .point_pulse (point_pulse),
    .game_over   (game_over),
    .winner      (winner)
  );

  always #5 clk = ~clk;

  // Model: is the ball live, how many hold cycles remain, and the score tally.
  int m_l = 0, m_r = 0, m_serve = 0;
  bit m_play = 0, m_fresh = 0, m_over = 0, m_win = 0, m_pulse = 0, m_prev = 0;

  function automatic bit m_wins(int s, int o);
`ifdef PONG_WIN_BY_TWO_EN
    return (s == 15) || (s >= W && s - o >= 2);
`else
    return s >= W;
`endif
  endfunction

  task automatic award(bit to_right);
    int s, o;
    if (to_right) begin
      if (m_r < 15) m_r = m_r + 1;
      s = m_r; o = m_l;
    end else begin
      if (m_l < 15) m_l = m_l + 1;
      s = m_l; o = m_r;
    end
    m_pulse = 1;
    m_play  = 0;
    if (m_wins(s, o)) begin
      m_over = 1;
      m_win  = to_right;
    end else begin
      m_serve = D;
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_l = 0; m_r = 0; m_serve = 0; m_play = 0; m_fresh = 0;
      m_over = 0; m_win = 0; m_pulse = 0; m_prev = 0;
    end else begin
      bit rise;
      rise   = start && !m_prev;
      m_prev = start;
      m_pulse = 0;
      if (m_play) begin
        if (m_fresh) m_fresh = 0;
        else if (x_pos <= 10'd4 || x_pos >= 10'd1000) award(1'b1);
        else if (x_pos >= 10'd636) award(1'b0);
      end else if (m_serve > 0) begin
        m_serve = m_serve - 1;
        if (m_serve == 0) begin
          m_play = 1; m_fresh = 1;
        end
      end else if (rise) begin
        m_l = 0; m_r = 0; m_over = 0; m_play = 1; m_fresh = 1;
      end
    end
  end

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_ball_reset", int'(ball_reset), int'(!m_play));
      chk("model_left_score", int'(left_score), m_l);
      chk("model_right_score", int'(right_score), m_r);
      chk("model_point_pulse", int'(point_pulse), int'(m_pulse));
      chk("model_game_over", int'(game_over), int'(m_over));
      if (m_over) chk("model_winner", int'(winner), int'(m_win));
    end
  end

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic goal_at(int x);
    x_pos = 10'(x);
    tick(1);
    x_pos = 10'd320;
  endtask

  task automatic serve_wait();
    tick(D);
    tick(1);
  endtask

  task automatic press_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  initial begin
    tick(2);
    cmp_en = 1'b1;
    reset  = 1'b0;
    tick(1);
    chk("reset_ball_reset", int'(ball_reset), 1);
    chk("reset_scores", int'({left_score, right_score}), 0);
    chk("reset_game_over", int'(game_over), 0);

    press_start();
    chk("start_ball_reset", int'(ball_reset), 0);
    tick(1);

    goal_at(2);
    chk("x2_right_score", int'(right_score), 1);
    chk("x2_pulse", int'(point_pulse), 1);
    chk("x2_ball_reset", int'(ball_reset), 1);
    tick(1);
    chk("x2_pulse_drop", int'(point_pulse), 0);
    tick(6);
    chk("serve_hold_7", int'(ball_reset), 1);
    tick(1);
    chk("serve_release_8", int'(ball_reset), 0);
    tick(1);

    goal_at(1023);
    chk("wrap_right_score", int'(right_score), 2);
    serve_wait();
    goal_at(637);
    chk("x637_left_score", int'(left_score), 1);
    serve_wait();
    goal_at(320);
    chk("x320_no_change", int'({left_score, right_score}), 8'h12);
    chk("x320_no_pulse", int'(point_pulse), 0);

    goal_at(2);
    chk("win_game_over", int'(game_over), 1);
    chk("win_winner", int'(winner), 1);
    chk("win_right_score", int'(right_score), 3);
    x_pos = 10'd2;
    tick(3);
    x_pos = 10'd320;
    chk("over_frozen", int'({left_score, right_score}), 8'h13);
    press_start();
    chk("restart_scores", int'({left_score, right_score}), 0);
    chk("restart_game_over", int'(game_over), 0);
    tick(1);

    goal_at(2);    serve_wait();
    goal_at(700);  serve_wait();
    goal_at(2);    serve_wait();
    goal_at(700);  serve_wait();
    goal_at(2);
`ifdef PONG_WIN_BY_TWO_EN
    chk("by2_3_2_not_over", int'(game_over), 0);
    chk("by2_3_2_hold", int'(ball_reset), 1);
    serve_wait();
    goal_at(1010);
    chk("by2_4_2_over", int'(game_over), 1);
    chk("by2_4_2_winner", int'(winner), 1);
    chk("by2_4_2_score", int'(right_score), 4);
`else
    chk("first_to_3_over", int'(game_over), 1);
    chk("first_to_3_winner", int'(winner), 1);
    chk("first_to_3_score", int'({left_score, right_score}), 8'h23);
`endif

    press_start();
    tick(1);
    goal_at(637);
    tick(4);
    reset = 1'b1;
    #1;
    chk("midpoint_reset_ball_reset", int'(ball_reset), 1);
    chk("midpoint_reset_scores", int'({left_score, right_score}), 0);
    tick(1);
    reset = 1'b0;
    press_start();
    tick(1);
    goal_at(2);
    tick(D - 1);
    chk("after_reset_full_hold", int'(ball_reset), 1);
    tick(1);
    chk("after_reset_release", int'(ball_reset), 0);

    for (int i = 0; i < 3000; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 8)       x_pos = 10'($urandom_range(0, 4));
      else if (r < 14) x_pos = 10'($urandom_range(1000, 1023));
      else if (r < 20) x_pos = 10'($urandom_range(636, 999));
      else             x_pos = 10'($urandom_range(5, 635));
      start = ($urandom_range(0, 15) == 0);
      reset = ($urandom_range(0, 399) == 0);
      tick(1);
    end
    reset = 1'b0;
    start = 1'b0;
    tick(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
